// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command front-end for a registered ALU
// Issues one opcode/operand set, waits out the ALU register stage, returns a captured response.
module alu_cmd_sequencer #(
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 7,
  parameter int CNT_WIDTH    = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OPCODE_WIDTH:0] cmd_opcode,
  input  logic [DATA_WIDTH:0]   cmd_op1,
  input  logic [DATA_WIDTH:0]   cmd_op2,
  input  logic                  cmd_chain,
  output logic [OPCODE_WIDTH:0] alu_opcode,
  output logic [DATA_WIDTH:0]   alu_op1,
  output logic [DATA_WIDTH:0]   alu_op2,
  input  logic [DATA_WIDTH:0]   alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH:0]   rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [CNT_WIDTH:0]    op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                state_q, state_d;
  logic [OPCODE_WIDTH:0] alu_opcode_q, alu_opcode_d;
  logic [DATA_WIDTH:0]   alu_op1_q, alu_op1_d;
  logic [DATA_WIDTH:0]   alu_op2_q, alu_op2_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH:0]   rsp_result_q, rsp_result_d;
  logic                  rsp_carry_q, rsp_carry_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [DATA_WIDTH:0]   last_result_q, last_result_d;
  logic [CNT_WIDTH:0]    op_count_q, op_count_d;
  logic                  accept;

  // In RESP a new command can only enter on the same edge the response leaves.
  assign cmd_ready = rstn & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d       = state_q;
    alu_opcode_d  = alu_opcode_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_zero_d    = rsp_zero_q;
    last_result_d = last_result_q;
    op_count_d    = op_count_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_result_d  = alu_result;
        rsp_carry_d   = alu_carry;
        rsp_zero_d    = alu_zero;
        last_result_d = alu_result;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d  = op_count_q + {{CNT_WIDTH{1'b0}}, 1'b1};
          rsp_valid_d = 1'b0;
          state_d     = accept ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      alu_opcode_d = cmd_opcode;
      alu_op1_d    = cmd_chain ? last_result_q : cmd_op1;
      alu_op2_d    = cmd_op2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      alu_opcode_q  <= '0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      last_result_q <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_zero_q    <= rsp_zero_d;
      last_result_q <= last_result_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
// Includes a registered 8-bit ALU stand-in and a response scoreboard.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic [7:0]  cmd_op1 = '0;
  logic [7:0]  cmd_op2 = '0;
  logic        cmd_chain = 1'b0;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic [7:0]  alu_result = '0;
  logic        alu_carry = 1'b0;
  logic        alu_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        busy;
  logic [15:0] op_count;

  typedef struct packed {
    logic [7:0] res;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tb_last = '0;
  logic [15:0] exp_count = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  alu_cmd_sequencer #(.OPCODE_WIDTH(2), .DATA_WIDTH(7), .CNT_WIDTH(15)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_chain(cmd_chain),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Returns {zero, carry, result}; carry is carry-out for add/inc and borrow for sub/dec.
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    case (op)
      3'd0: t = {1'b0, a} + {1'b0, b};
      3'd1: t = {1'b0, a} - {1'b0, b};
      3'd2: t = {1'b0, a} + 9'd1;
      3'd3: t = {1'b0, a} - 9'd1;
      3'd4: t = {1'b0, a & b};
      3'd5: t = {1'b0, a | b};
      3'd6: t = {1'b0, ~(a & b)};
      default: t = {1'b0, a ^ b};
    endcase
    return {(t[7:0] == 8'h00), t};
  endfunction

  always @(posedge clk) {alu_zero, alu_carry, alu_result} <= alu_f(alu_opcode, alu_op1, alu_op2);

  function automatic void push_expect(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    logic [9:0] f;
    f = alu_f(op, ch ? tb_last : a, b);
    exp_q.push_back('{res: f[7:0], carry: f[8], zero: f[9]});
    tb_last = f[7:0];
  endfunction

  // Called just after a falling edge; returns just after the falling edge following the accept edge.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    bit ok = 0;
    push_expect(op, a, b, ch);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_chain = ch;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: cmd_ready stayed 0, required 1");
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output exp_t obs, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1");
    end
    obs = '{res: rsp_result, carry: rsp_carry, zero: rsp_zero};
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, busy} !== 12'h0) begin n_fail++;
      $display("FAIL reset_rsp: got %b%h%b%b%b want all 0", rsp_valid, rsp_result, rsp_carry, rsp_zero, busy); end
    n_cmp++; if ({alu_opcode, alu_op1, alu_op2, op_count} !== 35'h0) begin n_fail++;
      $display("FAIL reset_alu_cnt: got %h %h %h %h want 0", alu_opcode, alu_op1, alu_op2, op_count); end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_add();
    exp_t obs, e;
    int lat;
    send_cmd(3'd0, 8'd200, 8'd100, 1'b0);
    n_cmp++; if ({busy, rsp_valid, cmd_ready} !== 3'b100) begin n_fail++;
      $display("FAIL add_issue_state: busy/rsp_valid/cmd_ready got %b%b%b want 100", busy, rsp_valid, cmd_ready); end
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
    n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL add_rsp: got %h want %h", obs, e); end
    n_cmp++; if (obs !== exp_t'({8'h2C, 1'b1, 1'b0})) begin n_fail++; $display("FAIL add_literal: got %h want 2c/1/0", obs); end
    @(negedge clk);
    exp_count++;
    n_cmp++; if (op_count !== exp_count || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_count: op_count %0d rsp_valid %b want %0d/0", op_count, rsp_valid, exp_count); end
  endtask

  task automatic test_zero_borrow();
    exp_t obs, e;
    int lat;
    send_cmd(3'd1, 8'd5, 8'd5, 1'b0);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e || obs !== exp_t'({8'h00, 1'b0, 1'b1})) begin n_fail++;
      $display("FAIL sub_zero: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
    send_cmd(3'd3, 8'd0, 8'd0, 1'b0);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e || obs !== exp_t'({8'hFF, 1'b1, 1'b0})) begin n_fail++;
      $display("FAIL dec_borrow: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
    n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL zb_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_chain();
    exp_t obs, e;
    int lat;
    send_cmd(3'd0, 8'd200, 8'd100, 1'b0);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL chain_first: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
    send_cmd(3'd2, 8'h77, 8'h00, 1'b1);
    n_cmp++; if (alu_op1 !== 8'h2C || alu_opcode !== 3'd2) begin n_fail++;
      $display("FAIL chain_op1: alu_op1 %h opcode %0d want 2c/2", alu_op1, alu_opcode); end
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e || obs !== exp_t'({8'h2D, 1'b0, 1'b0})) begin n_fail++;
      $display("FAIL chain_rsp: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
  endtask

  task automatic test_back_to_back();
    exp_t obs, e, held;
    int lat;
    logic [2:0] h_opc;
    logic [7:0] h_op1, h_op2;
    rsp_ready = 1'b0;
    send_cmd(3'd0, 8'h10, 8'h20, 1'b0);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL bp_first: got %h want %h", obs, e); end
    held = obs; h_opc = alu_opcode; h_op1 = alu_op1; h_op2 = alu_op2;
    push_expect(3'd7, 8'h3C, 8'h0F, 1'b1);
    cmd_valid = 1'b1; cmd_opcode = 3'd7; cmd_op1 = 8'h3C; cmd_op2 = 8'h0F; cmd_chain = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_result, rsp_carry, rsp_zero} !== held || rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
          {alu_opcode, alu_op1, alu_op2} !== {h_opc, h_op1, h_op2}) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: rsp %h v%b rdy%b alu %h%h%h want %h v1 rdy0 alu %h%h%h",
                 i, {rsp_result, rsp_carry, rsp_zero}, rsp_valid, cmd_ready, alu_opcode, alu_op1, alu_op2,
                 held, h_opc, h_op1, h_op2);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_count++;
    n_cmp++; if (op_count !== exp_count || rsp_valid !== 1'b0 || alu_op1 !== 8'h30 || alu_opcode !== 3'd7) begin n_fail++;
      $display("FAIL b2b_accept: cnt %0d v%b op1 %h opc %0d want %0d/0/30/7", op_count, rsp_valid, alu_op1, alu_opcode, exp_count); end
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", lat); end
    n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL b2b_rsp: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
  endtask

  task automatic test_logic();
    exp_t obs, e;
    int lat;
    send_cmd(3'd6, 8'hFF, 8'hFF, 1'b0);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e || obs !== exp_t'({8'h00, 1'b0, 1'b1})) begin n_fail++;
      $display("FAIL nand_rsp: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
    send_cmd(3'd7, 8'hA5, 8'h0F, 1'b0);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e || obs !== exp_t'({8'hAA, 1'b0, 1'b0})) begin n_fail++;
      $display("FAIL xor_rsp: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
    n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL logic_count: got %0d want %0d", op_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    exp_t obs, e;
    int lat;
    bit seen = 0;
    send_cmd(3'd0, 8'd1, 8'd1, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, busy, rsp_valid, rsp_result, rsp_carry, rsp_zero, alu_opcode, alu_op1, alu_op2, op_count} !== 48'h0) begin
      n_fail++;
      $display("FAIL midreset_clear: rdy%b busy%b v%b rsp %h%b%b alu %h %h %h cnt %0d want all 0",
               cmd_ready, busy, rsp_valid, rsp_result, rsp_carry, rsp_zero, alu_opcode, alu_op1, alu_op2, op_count);
    end
    exp_q.delete();
    tb_last = '0;
    exp_count = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL midreset_dropped: response or busy seen after release, want none"); end
    send_cmd(3'd2, 8'h55, 8'h00, 1'b1);
    wait_rsp(obs, lat);
    e = exp_q.pop_front();
    n_cmp++; if (obs !== e || obs.res !== 8'h01) begin n_fail++; $display("FAIL midreset_chain: got %h want %h", obs, e); end
    @(negedge clk); exp_count++;
    n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL midreset_count: got %0d want %0d", op_count, exp_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_zero_borrow();
    test_chain();
    test_back_to_back();
    test_logic();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command front-end placed directly upstream of the registered 8-bit ALU (alu).
- Accepts opcode/operand commands over a valid/ready handshake and drives the ALU's OPCODE/OP1/OP2 from registers.
- Waits out the ALU's one-cycle register latency, then captures RESULT/CARRY/ZERO into a response register with its own valid/ready handshake.
- Supports result chaining: the previous result can replace OP1.

Parameters:
OPCODE_WIDTH, 2, MSB index of opcode bus (opcode is OPCODE_WIDTH+1 bits).
DATA_WIDTH, 7, MSB index of data buses (data is DATA_WIDTH+1 bits).
CNT_WIDTH, 15, MSB index of completed-operation counter.

Ports:
clk  in  1  single clock, all state on rising edge.
rstn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept command this cycle.
cmd_opcode  in  OPCODE_WIDTH+1  ALU opcode: 0 add, 1 sub, 2 inc, 3 dec, 4 and, 5 or, 6 nand, 7 xor.
cmd_op1  in  DATA_WIDTH+1  operand 1.
cmd_op2  in  DATA_WIDTH+1  operand 2.
cmd_chain  in  1  1 = use last captured result as OP1; cmd_op1 ignored.
alu_opcode  out  OPCODE_WIDTH+1  to ALU OPCODE, registered.
alu_op1  out  DATA_WIDTH+1  to ALU OP1, registered.
alu_op2  out  DATA_WIDTH+1  to ALU OP2, registered.
alu_result  in  DATA_WIDTH+1  from ALU RESULT.
alu_carry  in  1  from ALU CARRY.
alu_zero  in  1  from ALU ZERO.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_result  out  DATA_WIDTH+1  captured result.
rsp_carry  out  1  captured carry.
rsp_zero  out  1  captured zero.
busy  out  1  state != IDLE.
op_count  out  CNT_WIDTH+1  completed responses, wraps modulo 2^(CNT_WIDTH+1).

Behaviour:
- Reset (async, rstn=0): all outputs and state 0.
  - state=IDLE; alu_* = 0; rsp_* = 0; last_result=0; op_count=0.
  - cmd_ready=0 only while rstn=0.
- FSM states are IDLE, ISSUE, CAPTURE, RESP.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready at edge E, load alu_opcode/alu_op1/alu_op2 and go to ISSUE.
  - alu_op1 = cmd_chain ? last_result : cmd_op1.
- ISSUE: one cycle with alu_* stable. The ALU registers its output at edge E+1. Go to CAPTURE.
- CAPTURE: one cycle. At edge E+2, latch alu_result/alu_carry/alu_zero verbatim into rsp_*. Also set last_result=alu_result, rsp_valid=1, and go to RESP.
- Latency: rsp_valid is high in the cycle after edge E+2, i.e. 2 edges after acceptance.
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0 (no change for any duration).
  - rsp_valid&rsp_ready at an edge: op_count += 1 (wraps), rsp_valid cleared.
  - cmd_ready = rsp_ready in RESP. If cmd_valid is also high, the new command is accepted at the same edge and the FSM goes straight to ISSUE (back-to-back). Otherwise it goes to IDLE.
  - Peak throughput: one op per 3 cycles.
- cmd_ready=0 in ISSUE and CAPTURE. cmd_valid there is ignored; the upstream holds it.
- alu_* registers hold their last value outside loads. rsp_result/carry/zero hold after handshake until the next capture.
- Chaining uses last_result from the most recent capture, whether or not that response has been consumed yet.
  - When a chained command is accepted in RESP at the same edge the response is consumed, the current rsp_result is used.
  - After reset, last_result=0.
- No width extension: the sequencer does no arithmetic. Flags are forwarded exactly as the ALU produced them.
- Reset mid-operation, in any state: immediate return to IDLE.
  - The in-flight command is dropped and no response is produced. op_count clears.
  - After rstn rises, the first edge may accept a command.
- op_count wraps from all-ones to 0 without any flag.

Test Plan:
- Single add, DATA_WIDTH=7: cmd opcode 0, op1=200, op2=100, rsp_ready=1 -> rsp_valid 2 edges after accept. rsp_result=44 (0x2C), carry=1, zero=0, op_count=1.
- Zero/borrow: sub 5-5 -> result 0, zero=1, carry=0. Then dec op1=0 -> result 0xFF, carry=1, zero=0.
- Chaining: add 200+100 (result 0x2C), then inc with cmd_chain=1 and cmd_op1=0x77 -> alu_op1=0x2C, rsp_result=0x2D, carry=0.
- Backpressure/back-to-back: hold rsp_ready=0 for 5 cycles after rsp_valid with the next cmd_valid high.
  - Required: rsp_* stable, cmd_ready=0, and alu_* unchanged throughout.
  - Raise rsp_ready: response consumed and new command accepted on the same edge. Next rsp_valid exactly 2 edges later.
- Logic op: nand op1=0xFF, op2=0xFF -> result 0x00, zero=1, carry=0. Then xor 0xA5^0x0F -> 0xAA, zero=0.
- Reset mid-op: accept add 1+1, assert rstn=0 during CAPTURE -> all outputs 0 asynchronously, no response after release. A following inc with cmd_chain=1 yields rsp_result=1.
